// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//
// Central sequencer for the 8-opcode, 5-bit-address RISC CPU. A fixed
// 8-phase instruction cycle is decoded, together with the live opcode and
// the accumulator zero flag, into every datapath control strobe.
//
// Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE,
//         4 OP_ADDR,   5 OP_FETCH,   6 ALU_OP,    7 STORE
//
// Parameters
//   OP_WIDTH  opcode width (only 3 is supported)
//   STALL_EN  1 = stall input freezes the phase, 0 = stall ignored
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset
//   stall   in   memory not ready, holds the current phase
//   opcode  in   current instruction opcode from the IR
//   zero    in   accumulator-equals-zero flag
//   sel     out  address mux select (1 = PC, 0 = IR operand address)
//   rd      out  memory read enable
//   wr      out  memory write strobe
//   ld_ir   out  instruction register load
//   ld_ac   out  accumulator load
//   inc_pc  out  program counter increment
//   ld_pc   out  program counter load from IR address
//   data_e  out  drive AC onto the data bus
//   halt    out  CPU halted
//   phase   out  current phase (debug)
// -----------------------------------------------------------------------------
module cpu_controller #(
  parameter int OP_WIDTH = 3,
  parameter bit STALL_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [OP_WIDTH-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                wr,
  output logic                ld_ir,
  output logic                ld_ac,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                data_e,
  output logic                halt,
  output logic [2:0]          phase
);

  localparam logic [OP_WIDTH-1:0] OP_HLT = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SKZ = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_LDA = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_STO = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_JMP = OP_WIDTH'(7);

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

  phase_t r_phase;
  logic   r_halted;
  // Cleared by reset and set on the first edge after release, so that the
  // release edge itself never advances the phase.
  logic   r_run;

  logic w_stall;
  logic w_is_hlt;
  logic w_is_skz;
  logic w_is_sto;
  logic w_is_jmp;
  logic w_aluop;

  assign w_stall  = STALL_EN && stall;
  assign w_is_hlt = (opcode == OP_HLT);
  assign w_is_skz = (opcode == OP_SKZ);
  assign w_is_sto = (opcode == OP_STO);
  assign w_is_jmp = (opcode == OP_JMP);
  assign w_aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase  <= PH_INST_ADDR;
      r_halted <= 1'b0;
      r_run    <= 1'b0;
    end else if (!r_run) begin
      r_run <= 1'b1;
    end else if (!r_halted && !w_stall) begin
      // HLT freezes the sequencer in OP_ADDR on the edge that would advance.
      if ((r_phase == PH_OP_ADDR) && w_is_hlt) begin
        r_halted <= 1'b1;
      end else begin
        r_phase <= phase_t'(r_phase + 3'd1);
      end
    end
  end

  // Output decode. Reset and halt override the per-phase table so that a
  // mid-instruction reset drops wr without waiting for a clock edge.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    phase  = r_phase;

    if (!rst) begin
      phase = 3'd0;
    end else if (r_halted) begin
      halt = 1'b1;
    end else begin
      case (r_phase)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = w_is_hlt;
        end
        PH_OP_FETCH: begin
          rd = w_aluop;
        end
        PH_ALU_OP: begin
          rd     = w_aluop;
          // SKZ taken: second increment inside the same instruction cycle.
          inc_pc = w_is_skz && zero;
          ld_pc  = w_is_jmp;
          data_e = w_is_sto;
        end
        PH_STORE: begin
          rd     = w_aluop;
          ld_ac  = w_aluop;
          ld_pc  = w_is_jmp;
          wr     = w_is_sto;
          data_e = w_is_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
//
// The driver issues one stimulus per clock, advances a phase-level model of
// the instruction cycle and queues the outputs that the model predicts for
// that cycle. A separate monitor pops each prediction and compares it with
// the DUT. A small program counter in the bench follows ld_pc/inc_pc; its
// value at each instruction start is predicted per instruction as
// JMP ? target : pc + 1 + (SKZ && zero).
// -----------------------------------------------------------------------------
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stall = 1'b0;
  logic [2:0] opcode = 3'd2;
  logic       zero = 1'b0;
  logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
  logic [2:0] phase;

  logic [4:0] ir_addr = 5'd0;
  logic [4:0] pc_init = 5'd0;
  logic [4:0] tb_pc;

  cpu_controller #(.OP_WIDTH(3), .STALL_EN(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  // Bench program counter driven by the controller strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tb_pc <= pc_init;
    else if (ld_pc) tb_pc <= ir_addr;
    else if (inc_pc) tb_pc <= tb_pc + 5'd1;
  end

  typedef struct {
    string      nm;
    logic [11:0] exp;
    bit         chk_pc;
    logic [4:0] exp_pc;
  } exp_t;

  exp_t q[$];
  event ev_push;
  int   n_checks = 0;
  int   n_fail = 0;

  // Model state
  int         m_ph = 0;
  bit         m_halt = 0;
  bit         m_run = 0;
  logic [4:0] m_pc = 5'd0;
  logic [2:0] cur_op = 3'd2;
  bit         cur_z = 0;
  string      tag = "init";

  // Expected {sel,rd,wr,ld_ir,ld_ac,inc_pc,ld_pc,data_e,halt,phase[2:0]}
  function automatic logic [11:0] model_out(int ph, bit h, bit r, logic [2:0] op, bit z);
    bit s = 0, rd_e = 0, wr_e = 0, ir_e = 0, ac_e = 0, inc_e = 0, ldpc_e = 0, de_e = 0, hl_e = 0;
    bit alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    if (!r) return 12'd0;
    if (h) return {9'b000000001, 3'd4};
    case (ph)
      0: s = 1;
      1: begin s = 1; rd_e = 1; end
      2, 3: begin s = 1; rd_e = 1; ir_e = 1; end
      4: begin inc_e = 1; hl_e = (op == 3'd0); end
      5: rd_e = alu;
      6: begin rd_e = alu; inc_e = (op == 3'd1) && z; ldpc_e = (op == 3'd7); de_e = (op == 3'd6); end
      default: begin rd_e = alu; ac_e = alu; ldpc_e = (op == 3'd7); wr_e = (op == 3'd6); de_e = (op == 3'd6); end
    endcase
    return {s, rd_e, wr_e, ir_e, ac_e, inc_e, ldpc_e, de_e, hl_e, 3'(ph)};
  endfunction

  task automatic push();
    exp_t e;
    e.nm     = tag;
    e.exp    = model_out(m_ph, m_halt, rst, cur_op, cur_z);
    e.chk_pc = rst && !m_halt && (m_ph == 0);
    e.exp_pc = m_pc;
    q.push_back(e);
    -> ev_push;
  endtask

  task automatic model_reset();
    m_ph = 0; m_halt = 0; m_run = 0; m_pc = pc_init;
  endtask

  // Effect of one rising edge on the instruction-cycle model.
  task automatic model_edge(input bit st);
    if (!rst) return;
    if (!m_run) m_run = 1;
    else if (m_halt || st) begin end
    else if (m_ph == 4 && cur_op == 3'd0) m_halt = 1;
    else if (m_ph == 7) begin
      if (cur_op == 3'd7) m_pc = ir_addr;
      else m_pc = m_pc + 5'd1 + ((cur_op == 3'd1 && cur_z) ? 5'd1 : 5'd0);
      m_ph = 0;
    end else m_ph = m_ph + 1;
  endtask

  task automatic step(input bit st);
    stall = st;
    push();
    @(posedge clk);
    model_edge(st);
    #1;
  endtask

  task automatic do_reset(input logic [4:0] init);
    pc_init = init;
    rst = 1'b0;
    model_reset();
    step(0);
    step(0);
    rst = 1'b1;
  endtask

  task automatic set_instr(input logic [2:0] op, input bit z, input logic [4:0] a);
    cur_op = op; cur_z = z;
    opcode = op; zero = z; ir_addr = a;
  endtask

  // Runs one instruction from P0 back to P0 (or until halted).
  task automatic run_instr(input logic [2:0] op, input bit z, input logic [4:0] a, input bit rnd_stall);
    bit left = 0;
    bit st;
    set_instr(op, z, a);
    for (int k = 0; k < 48; k++) begin
      st = 0;
      if (rnd_stall && m_ph != 6 && !(m_ph == 4 && op != 3'd0))
        st = ($urandom_range(0, 3) == 0);
      step(st);
      if (m_halt) break;
      if (m_ph != 0) left = 1;
      if (left && m_ph == 0) break;
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [11:0] act;
    forever begin
      @(ev_push);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        act = {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase};
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s outputs t=%0t act=%b exp=%b", e.nm, $time, act, e.exp);
        end
        if (e.chk_pc) begin
          n_checks++;
          if (tb_pc !== e.exp_pc) begin
            n_fail++;
            $display("FAIL %s pc t=%0t act=%b exp=%b", e.nm, $time, tb_pc, e.exp_pc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    #2;
    // Reset and basic sequence with ADD
    tag = "reset_seq";
    set_instr(3'd2, 0, 5'd0);
    do_reset(5'd0);
    for (int k = 0; k < 10; k++) step(0);

    // JMP from PC=00011 to 10101
    tag = "jmp";
    do_reset(5'b00011);
    run_instr(3'd7, 0, 5'b10101, 0);
    step(0);

    // SKZ taken and not taken
    tag = "skz_taken";
    do_reset(5'b00010);
    run_instr(3'd1, 1, 5'd9, 0);
    step(0);
    tag = "skz_not";
    do_reset(5'b00010);
    run_instr(3'd1, 0, 5'd9, 0);
    step(0);

    // STO
    tag = "sto";
    do_reset(5'd4);
    run_instr(3'd6, 0, 5'd17, 0);
    step(0);

    // HLT, then 20 halted cycles with toggling stall, then reset
    tag = "hlt";
    do_reset(5'd1);
    run_instr(3'd0, 0, 5'd0, 0);
    for (int k = 0; k < 20; k++) step(k[0]);
    tag = "hlt_reset";
    do_reset(5'd0);
    step(0);

    // Stall in P1 for three edges
    tag = "stall_p1";
    set_instr(3'd2, 0, 5'd0);
    do_reset(5'd0);
    step(0);
    step(0);
    for (int k = 0; k < 3; k++) step(1);
    for (int k = 0; k < 3; k++) step(0);

    // Reset asserted mid-P7 of STO drops wr before any edge
    tag = "rst_mid_sto";
    set_instr(3'd6, 0, 5'd3);
    do_reset(5'd0);
    for (int k = 0; k < 20 && m_ph != 7; k++) step(0);
    push();
    #4;
    rst = 1'b0;
    model_reset();
    push();
    @(posedge clk);
    #1;
    step(0);
    rst = 1'b1;

    // Randomized instruction stream
    tag = "random";
    do_reset(5'($urandom_range(0, 31)));
    for (int n = 0; n < 40; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 11) == 0) op = 3'd0;
      run_instr(op, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1);
      if (m_halt) begin
        for (int k = 0; k < 4; k++) step(1'($urandom_range(0, 1)));
        do_reset(5'($urandom_range(0, 31)));
      end
    end
    step(0);

    #5;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
